uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one uart_tx byte transmitter between N_REQ independent packet sources (e.g. order status, sensor telemetry, debug).
- Arbitrates round-robin and locks the grant for a whole packet.
- Wraps each packet as SOF, header (source id), payload, XOR checksum, so the WiFi NANO side can demultiplex sources.
- Sits directly upstream of uart_tx and drives its data/valid/ready handshake.

Parameters:
N_REQ, 3, number of requesters (2..8)
MAX_LEN, 16, maximum payload bytes per packet before forced truncation (1..255)
SOF_BYTE, 8'h7E, start-of-frame byte
HDR_TAG, 4'hA, upper nibble of the header byte

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req_data  in  8*N_REQ  payload byte per requester; requester i uses bits [8i+7:8i]
req_valid  in  N_REQ  requester i has a byte available
req_last  in  N_REQ  byte is the final byte of its packet
req_ready  out  N_REQ  byte accepted when req_valid[i] && req_ready[i]
tx_data  out  8  byte to uart_tx data_tx
tx_valid  out  1  to uart_tx valid_in
tx_ready  in  1  from uart_tx ready_out
busy  out  1  high from grant until checksum accepted
grant_id  out  $clog2(N_REQ)  currently/last granted requester
err_trunc  out  1  one-cycle pulse when a packet is truncated at MAX_LEN

Behaviour:
- Reset values: clk and reset are single clock, synchronous active-high rst. On rst: state IDLE, tx_valid=0, tx_data=0, req_ready=0, busy=0, grant_id=0, err_trunc=0, checksum=0, byte count=0, RR pointer=0 (requester 0 highest priority).
- Reset mid-packet: abandons the packet; tx_valid is low the cycle after rst. No partial checksum is sent.
- Output stage: tx_data/tx_valid are registered (one-entry buffer).
  - A byte transfers on tx_valid && tx_ready.
  - Once tx_valid is high, tx_data and tx_valid are held stable until the transfer.
  - The buffer may reload in the same cycle it drains.
- States: IDLE, SOF, HDR, PAYLOAD, CSUM.
- IDLE:
  - When any req_valid is set, pick the winner round-robin starting at (last grant + 1) mod N_REQ.
  - Register grant_id, set busy, load SOF_BYTE into the buffer, go to SOF.
  - Arbitration takes 1 cycle from req_valid to tx_valid.
- SOF: on SOF transfer, load header {HDR_TAG, id zero-extended to 4 bits}; checksum := header; go to HDR.
- HDR: on header transfer, go to PAYLOAD.
- PAYLOAD:
  - req_ready[grant_id] = (buffer empty or draining this cycle). All other req_ready bits are 0.
  - On an accepted byte: load it into the buffer, checksum ^= byte, count++.
  - Accepted with req_last → CSUM.
  - Accepted without req_last when count reaches MAX_LEN → CSUM, pulse err_trunc. Later bytes from that requester start a fresh packet at a later grant.
  - A stalled requester (req_valid low) holds the grant indefinitely; there is no timeout.
- CSUM:
  - Once the last payload byte transfers, load the checksum into the buffer.
  - On checksum transfer: clear busy and count, advance the RR pointer to grant_id+1 (wrap at N_REQ), go to IDLE.
- Minimum packet: SOF, HDR, 1 payload byte, CSUM = 4 UART bytes.
- Simultaneous requests in IDLE: only the RR winner is granted. Others wait with req_ready=0 and must hold their data.
- req_valid dropping while not granted is legal; it is ignored.
- Checksum covers the header and payload only, not SOF.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum arb_state_t
  - SOF_DEFAULT = 8'h7E
  - HDR_TAG_DEFAULT = 4'hA
  - function make_hdr(id)
- One sub-module, rr_arbiter: parameter N, inputs req[N], ptr; outputs gnt_onehot, gnt_id, any. It is purely combinational priority rotation; the pointer register stays in uart_tx_arbiter.

Test Plan:
1. Single packet. Requester 1 sends 0x11,0x22 (last on 0x22); tx_ready always high.
   → tx bytes 7E, A1, 11, 22, checksum A1^11^22 = 0x92; busy falls after 0x92; grant_id=1.
2. Contention. All three requesters hold 1-byte packets (0xC0,0xC1,0xC2) from reset.
   → grant order 0,1,2; each packet is framed; the next SOF never appears before the previous checksum transfers.
3. Back-pressure. tx_ready toggles 1 cycle high / 9 low (UART pacing) during a 3-byte packet.
   → tx_data is stable while tx_valid && !tx_ready; no byte is lost or duplicated; req_ready is high only in cycles the buffer is free.
4. Truncation. MAX_LEN=4; requester 0 streams 6 bytes 01..06, last on 06.
   → packet1 payload 01..04, err_trunc pulses once, checksum A0^01^02^03^04 = 0xA4; packet2 payload 05,06.
5. Reset mid-payload. Assert rst for 1 cycle after the second payload byte is accepted.
   → tx_valid=0, busy=0, req_ready=0 next cycle. The next request restarts with SOF and RR pointer 0.
6. Requester stall. The granted requester drops req_valid for 50 cycles mid-packet while another requests.
   → the grant is held, no bytes are sent during the stall, and the other requester is granted only after the stalled packet's checksum.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding, framing defaults and header helper for uart_tx_arbiter
package uart_arb_pkg;
    typedef enum logic [2:0] {IDLE, SOF, HDR, PAYLOAD, CSUM} arb_state_t;
    localparam logic [7:0] SOF_DEFAULT = 8'h7E;
    localparam logic [3:0] HDR_TAG_DEFAULT = 4'hA;
    function automatic logic [7:0] make_hdr(input logic [3:0] id, input logic [3:0] tag = HDR_TAG_DEFAULT);
        return {tag, id};
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, priority starting at ptr
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_onehot,
    output logic [$clog2(N)-1:0] gnt_id,
    output logic                 any
);
    localparam int W = $clog2(N);
    logic [W-1:0] idx;
    always_comb begin
        gnt_id = '0;
        any = 1'b0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = W'((int'(ptr) + k) % N);
            if (req[idx]) begin
                gnt_id = idx;
                any = 1'b1;
            end
        end
    end
    assign gnt_onehot = any ? (N'(1) << gnt_id) : '0;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter framing SOF/header/payload/XOR checksum into one uart_tx
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int          N_REQ    = 3,
    parameter int          MAX_LEN  = 16,
    parameter logic [7:0]  SOF_BYTE = SOF_DEFAULT,
    parameter logic [3:0]  HDR_TAG  = HDR_TAG_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       err_trunc
);
    localparam int IW = $clog2(N_REQ);
    arb_state_t st, st_n;
    logic [IW-1:0] ptr, arb_id;
    logic [N_REQ-1:0] arb_oh, gnt_q;
    logic arb_any, free, drain, acc, ld, start, fin, trunc, csum_ld, sel_valid, sel_last, last_slot;
    logic [7:0] csum, cnt, ld_byte, sel_data, hdr;

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req(req_valid),
        .ptr(ptr),
        .gnt_onehot(arb_oh),
        .gnt_id(arb_id),
        .any(arb_any)
    );

    assign drain = tx_valid && tx_ready;
    assign free = !tx_valid || tx_ready;
    assign sel_data = req_data[8*grant_id +: 8];
    assign sel_valid = req_valid[grant_id];
    assign sel_last = req_last[grant_id];
    assign hdr = make_hdr(4'(grant_id), HDR_TAG);
    assign last_slot = cnt == 8'(MAX_LEN - 1);
    assign req_ready = (st == PAYLOAD && free) ? gnt_q : '0;
    assign acc = st == PAYLOAD && free && sel_valid;

    always_comb begin
        st_n = st;
        ld = 1'b0;
        ld_byte = sel_data;
        start = 1'b0;
        fin = 1'b0;
        trunc = 1'b0;
        case (st)
            IDLE: if (arb_any) begin
                start = 1'b1;
                ld = 1'b1;
                ld_byte = SOF_BYTE;
                st_n = SOF;
            end
            SOF: if (drain) begin
                ld = 1'b1;
                ld_byte = hdr;
                st_n = HDR;
            end
            HDR: st_n = drain ? PAYLOAD : HDR;
            PAYLOAD: if (acc) begin
                ld = 1'b1;
                st_n = (sel_last || last_slot) ? CSUM : PAYLOAD;
                trunc = !sel_last && last_slot;
            end
            CSUM: if (!csum_ld && free) begin
                ld = 1'b1;
                ld_byte = csum;
            end else if (csum_ld && drain) begin
                fin = 1'b1;
                st_n = IDLE;
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st <= IDLE;
            tx_valid <= 1'b0;
            tx_data <= '0;
            grant_id <= '0;
            gnt_q <= '0;
            busy <= 1'b0;
            err_trunc <= 1'b0;
            csum <= '0;
            cnt <= '0;
            csum_ld <= 1'b0;
            ptr <= '0;
        end else begin
            st <= st_n;
            err_trunc <= trunc;
            if (ld) begin
                tx_valid <= 1'b1;
                tx_data <= ld_byte;
            end else if (drain) tx_valid <= 1'b0;
            if (start) begin
                grant_id <= arb_id;
                gnt_q <= arb_oh;
                busy <= 1'b1;
            end
            if (st == SOF && drain) csum <= hdr;
            if (acc) begin
                csum <= csum ^ sel_data;
                cnt <= cnt + 8'd1;
            end
            if (st == CSUM && ld) csum_ld <= 1'b1;
            if (fin) begin
                busy <= 1'b0;
                cnt <= '0;
                csum_ld <= 1'b0;
                ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random framing/arbitration checks against a frame-level model
module tb_uart_tx_arbiter;
    localparam int N = 3;
    localparam int ML = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0] req_valid = '0, req_last = '0, req_ready;
    logic [7:0] tx_data;
    logic tx_valid, tx_ready = 1'b1, busy, err_trunc;
    logic [1:0] grant_id;

    uart_tx_arbiter #(.N_REQ(N), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .grant_id(grant_id), .err_trunc(err_trunc)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] src_d [N][$];
    bit src_l [N][$];
    logic [7:0] ref_d [N][$];
    bit ref_l [N][$];
    logic [7:0] exp_q[$], obs_log[$];
    bit en[N];
    int rdy_mode = 0, rdy_cnt = 0;
    bit m_idle = 1'b1;
    int m_ptr = 0, m_len = 0, m_tx = 0, m_cur = 0;
    int trunc_exp = 0, trunc_seen = 0, stall_tx = 0;
    int acc_cnt[N];
    bit hold = 1'b0;
    logic [7:0] hold_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = en[i] && src_d[i].size() > 0;
            if (src_d[i].size() > 0) begin
                req_data[8*i +: 8] = src_d[i][0];
                req_last[i] = src_l[i][0];
            end
        end
        tx_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? (rdy_cnt % 10 == 0) : 1'($urandom_range(0, 1));
        rdy_cnt++;
    endtask

    function automatic int build_frame(input int id);
        logic [7:0] c = 8'hA0 | 8'(id);
        logic [7:0] b;
        int n = 0;
        bit done = 1'b0, l;
        exp_q.push_back(8'h7E);
        exp_q.push_back(c);
        while (!done && ref_d[id].size() > 0) begin
            b = ref_d[id].pop_front();
            l = ref_l[id].pop_front();
            exp_q.push_back(b);
            c ^= b;
            n++;
            if (l) done = 1'b1;
            else if (n == ML) begin
                done = 1'b1;
                trunc_exp++;
            end
        end
        exp_q.push_back(c);
        return n + 3;
    endfunction

    task automatic tick();
        bit txf, was_rst, et;
        logic [7:0] txb, e;
        logic [N-1:0] rf;
        int w;
        @(negedge clk);
        txf = tx_valid && tx_ready;
        txb = tx_data;
        rf = req_valid & req_ready;
        was_rst = rst;
        et = err_trunc;
        if (!was_rst) begin
            chk("ready_when_free", 32'(req_ready & ~{N{!tx_valid || tx_ready}}), 0);
            if (hold) begin
                chk("hold_valid", 32'(tx_valid), 1);
                chk("hold_data", 32'(tx_data), 32'(hold_d));
            end
            hold = tx_valid && !tx_ready;
            hold_d = tx_data;
            if (m_idle && |req_valid) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_cur = w;
                m_len = build_frame(w);
                m_tx = 0;
                m_idle = 1'b0;
            end
            chk("accept_granted_only", 32'(rf & ~(m_idle ? 3'b000 : 3'(1 << m_cur))), 0);
            if (et) trunc_seen++;
        end
        @(posedge clk);
        #1;
        if (!was_rst) begin
            if (txf) begin
                obs_log.push_back(txb);
                stall_tx++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("tx_byte", 32'(txb), 32'(e));
                end else chk("tx_extra", 32'(txb), 32'hxxxxxxxx);
                m_tx++;
                if (!m_idle && m_tx == m_len) begin
                    m_idle = 1'b1;
                    m_ptr = (m_cur + 1) % N;
                end
            end
            for (int i = 0; i < N; i++)
                if (rf[i] && src_d[i].size() > 0) begin
                    void'(src_d[i].pop_front());
                    void'(src_l[i].pop_front());
                    acc_cnt[i]++;
                end
        end
        drive();
    endtask

    task automatic add_pkt(input int i, input logic [7:0] b[$]);
        for (int k = 0; k < b.size(); k++) begin
            src_d[i].push_back(b[k]);
            src_l[i].push_back(k == b.size() - 1);
            ref_d[i].push_back(b[k]);
            ref_l[i].push_back(k == b.size() - 1);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_tx_valid", 32'(tx_valid), 0);
        chk("rst_tx_data", 32'(tx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_err_trunc", 32'(err_trunc), 0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_d[i].delete();
            src_l[i].delete();
            ref_d[i].delete();
            ref_l[i].delete();
        end
        exp_q.delete();
        obs_log.delete();
        m_idle = 1'b1;
        m_ptr = 0;
        hold = 1'b0;
        drive();
    endtask

    function automatic bit all_done();
        bit d = exp_q.size() == 0 && m_idle;
        for (int i = 0; i < N; i++) d &= src_d[i].size() == 0;
        return d;
    endfunction

    task automatic wait_done(input string tag, input int budget, input bit jitter);
        int n = 0;
        while (!all_done() && n < budget) begin
            if (jitter) begin
                for (int i = 0; i < N; i++) en[i] = $urandom_range(0, 3) != 0;
                drive();
            end
            tick();
            n++;
        end
        chk({tag, "_in_time"}, 32'(n < budget), 1);
        chk({tag, "_busy_low"}, 32'(busy), 0);
    endtask

    task automatic check_log(input string tag, input logic [7:0] e[$]);
        chk({tag, "_len"}, obs_log.size(), e.size());
        for (int k = 0; k < e.size() && k < obs_log.size(); k++) chk(tag, 32'(obs_log[k]), 32'(e[k]));
        obs_log.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [7:0] q[$];
        for (int i = 0; i < N; i++) begin
            en[i] = 1'b1;
            acc_cnt[i] = 0;
        end
        do_reset();
        // contention from reset: RR order 0,1,2
        add_pkt(0, '{8'hC0});
        add_pkt(1, '{8'hC1});
        add_pkt(2, '{8'hC2});
        drive();
        wait_done("t2", 200, 1'b0);
        check_log("t2_stream", '{8'h7E, 8'hA0, 8'hC0, 8'h60, 8'h7E, 8'hA1, 8'hC1, 8'h60, 8'h7E, 8'hA2, 8'hC2, 8'h60});
        // single packet, one-cycle arbitration latency
        add_pkt(1, '{8'h11, 8'h22});
        drive();
        tick();
        chk("t1_latency", 32'(tx_valid), 1);
        chk("t1_sof", 32'(tx_data), 32'h7E);
        chk("t1_busy", 32'(busy), 1);
        wait_done("t1", 200, 1'b0);
        check_log("t1_stream", '{8'h7E, 8'hA1, 8'h11, 8'h22, 8'h92});
        chk("t1_grant", 32'(grant_id), 1);
        // UART pacing back-pressure
        rdy_mode = 1;
        rdy_cnt = 1;
        add_pkt(2, '{8'h33, 8'h44, 8'h55});
        drive();
        wait_done("t3", 600, 1'b0);
        check_log("t3_stream", '{8'h7E, 8'hA2, 8'h33, 8'h44, 8'h55, 8'h80});
        rdy_mode = 0;
        // truncation at MAX_LEN
        trunc_seen = 0;
        trunc_exp = 0;
        add_pkt(0, '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        drive();
        wait_done("t4", 300, 1'b0);
        check_log("t4_stream", '{8'h7E, 8'hA0, 8'h01, 8'h02, 8'h03, 8'h04, 8'hA4, 8'h7E, 8'hA0, 8'h05, 8'h06, 8'hA3});
        chk("t4_trunc_pulses", trunc_seen, 1);
        // granted requester stalls while another requests
        base = acc_cnt[0];
        add_pkt(0, '{8'hD1, 8'hD2, 8'hD3});
        drive();
        for (int n = 0; n < 100 && acc_cnt[0] < base + 1; n++) tick();
        chk("t6_first_accept", acc_cnt[0], base + 1);
        en[0] = 1'b0;
        add_pkt(1, '{8'hE1});
        drive();
        repeat (2) tick();
        stall_tx = 0;
        repeat (48) tick();
        chk("t6_stall_no_tx", stall_tx, 0);
        chk("t6_stall_busy", 32'(busy), 1);
        chk("t6_stall_grant", 32'(grant_id), 0);
        en[0] = 1'b1;
        drive();
        wait_done("t6", 300, 1'b0);
        check_log("t6_stream", '{8'h7E, 8'hA0, 8'hD1, 8'hD2, 8'hD3, 8'h70, 8'h7E, 8'hA1, 8'hE1, 8'h40});
        // reset after the second payload byte, then pointer must restart at 0
        base = acc_cnt[2];
        add_pkt(2, '{8'hF1, 8'hF2, 8'hF3, 8'hF4});
        drive();
        for (int n = 0; n < 100 && acc_cnt[2] < base + 2; n++) tick();
        chk("t5_two_accepted", acc_cnt[2], base + 2);
        do_reset();
        add_pkt(1, '{8'hB1});
        add_pkt(2, '{8'hB2});
        drive();
        wait_done("t5", 200, 1'b0);
        check_log("t5_stream", '{8'h7E, 8'hA1, 8'hB1, 8'h10, 8'h7E, 8'hA2, 8'hB2, 8'h10});
        // random traffic, random pacing and random requester stalls
        trunc_seen = 0;
        trunc_exp = 0;
        rdy_mode = 2;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < N; i++)
                repeat ($urandom_range(0, 2)) begin
                    q.delete();
                    repeat ($urandom_range(1, 6)) q.push_back(8'($urandom_range(0, 255)));
                    add_pkt(i, q);
                end
            wait_done("rand", 2000, 1'b1);
            obs_log.delete();
        end
        chk("rand_trunc_pulses", trunc_seen, trunc_exp);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
